// File: rtl/pit_multi.sv
`default_nettype none
// ============================================================================
// Module   : pit_multi
// Brief    : Multi-channel programmable interval timer. NUM_CH independent
//            down-counters share one programmable prescaler; each channel is
//            one-shot or periodic, pulses tick on expiry and latches a
//            maskable interrupt-pending bit.
// Options  : PIT_READBACK_EN adds rd_ch / rd_count counter readback.
// Revision : 1.0 - initial release
// ============================================================================
module pit_multi #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [1:0]        wr_sel,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [NUM_CH-1:0] irq_ack,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] irq_pend,
  output logic              irq
`ifdef PIT_READBACK_EN
  ,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_count
`endif
);

  localparam logic [1:0] c_sel_reload = 2'd0;
  localparam logic [1:0] c_sel_ctrl   = 2'd1;
  localparam logic [1:0] c_sel_presc  = 2'd2;

  // Per-channel run state; en of the control register is the RUN state.
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } ch_state_e;

  logic [NUM_CH-1:0]  ch_hit;
  logic [NUM_CH-1:0]  irq_en_vec;
  logic               wr_ch_ok;
  logic               presc_wr;
  logic               strobe;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pc_q, pc_d;

  // A channel index with no channel behind it makes the whole write a no-op.
  assign wr_ch_ok = |ch_hit;
  assign presc_wr = wr_en & wr_ch_ok & (wr_sel == c_sel_presc);
  assign strobe   = ena & (pc_q == presc_q);
  assign irq      = |(irq_pend & irq_en_vec);

  // Prescaler: pc runs 0..presc, a write restarts the strobe phase.
  always_comb begin
    presc_d = presc_q;
    pc_d    = pc_q;
    if (presc_wr) begin
      presc_d = wr_data[PRESC_W-1:0];
      pc_d    = '0;
    end else if (strobe) begin
      pc_d = '0;
    end else if (ena) begin
      pc_d = pc_q + 1'b1;
    end
  end

  // Prescaler registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      pc_q    <= '0;
    end else begin
      presc_q <= presc_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PIT_READBACK_EN
  logic [CNT_W-1:0] count_vec [NUM_CH];
  logic [CNT_W-1:0] rd_count_q, rd_count_d;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             periodic_q, periodic_d;
    logic             irq_en_q, irq_en_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             ctrl_wr, reload_wr;

    assign ch_hit[i]     = (wr_ch == CH_W'(i));
    assign ctrl_wr       = wr_en & ch_hit[i] & (wr_sel == c_sel_ctrl);
    assign reload_wr     = wr_en & ch_hit[i] & (wr_sel == c_sel_reload);
    assign tick[i]       = tick_q;
    assign irq_pend[i]   = pend_q;
    assign irq_en_vec[i] = irq_en_q;
`ifdef PIT_READBACK_EN
    assign count_vec[i]  = count_q;
`endif

    // Channel next state: a control write overrides any strobe on that edge;
    // the zero test precedes the decrement; an expiry set beats an ack.
    always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      reload_d   = reload_q;
      periodic_d = periodic_q;
      irq_en_d   = irq_en_q;
      tick_d     = 1'b0;
      pend_d     = pend_q & ~irq_ack[i];
      if (reload_wr) begin
        reload_d = wr_data;
      end
      if (ctrl_wr) begin
        state_d    = wr_data[0] ? S_RUN : S_IDLE;
        periodic_d = wr_data[1];
        irq_en_d   = wr_data[2];
        if (wr_data[0]) begin
          count_d = reload_q;
        end
      end else if ((state_q == S_RUN) && strobe) begin
        if (count_q == '0) begin
          tick_d = 1'b1;
          pend_d = 1'b1;
          if (periodic_q) begin
            count_d = reload_q;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end

    // Channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= S_IDLE;
        count_q    <= '0;
        reload_q   <= '0;
        periodic_q <= 1'b0;
        irq_en_q   <= 1'b0;
        tick_q     <= 1'b0;
        pend_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        count_q    <= count_d;
        reload_q   <= reload_d;
        periodic_q <= periodic_d;
        irq_en_q   <= irq_en_d;
        tick_q     <= tick_d;
        pend_q     <= pend_d;
      end
    end
  end

`ifdef PIT_READBACK_EN
  // Readback mux; an index with no channel behind it reads 0.
  always_comb begin
    rd_count_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        rd_count_d = count_vec[i];
      end
    end
  end

  // Readback register, one cycle behind the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
    end
  end

  assign rd_count = rd_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pit_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pit_multi
// Brief    : Self-checking bench for pit_multi (3 channels, so one wr_ch
//            value addresses no channel). Directed scenarios followed by a
//            randomized phase, all compared with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pit_multi;

  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int PW  = 8;

  logic           clk;
  logic           rst_n;
  logic           ena;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [1:0]     wr_sel;
  logic [CW-1:0]  wr_data;
  logic [NCH-1:0] irq_ack;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] irq_pend;
  logic           irq;
  logic [1:0]     rd_ch;
`ifdef PIT_READBACK_EN
  logic [CW-1:0]  rd_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int m_count  [NCH];
  int m_reload [NCH];
  bit m_en     [NCH];
  bit m_per    [NCH];
  bit m_ien    [NCH];
  bit m_tick   [NCH];
  bit m_pend   [NCH];
  int m_presc;
  int m_pc;
  int m_rd;

  pit_multi #(.NUM_CH(NCH), .CNT_W(CW), .PRESC_W(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .irq_ack  (irq_ack),
    .tick     (tick),
    .irq_pend (irq_pend),
    .irq      (irq)
`ifdef PIT_READBACK_EN
    ,
    .rd_ch    (rd_ch),
    .rd_count (rd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_count[c] = 0; m_reload[c] = 0; m_en[c] = 0; m_per[c] = 0;
      m_ien[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
    end
    m_presc = 0; m_pc = 0; m_rd = 0;
  endtask

  // One clock edge of the timer as described by its rules.
  task automatic model_step();
    bit strobe;
    bit set;
    bit sel;
    strobe = ena && (m_pc == m_presc);
    m_rd = 0;
    if (int'(rd_ch) < NCH) m_rd = m_count[rd_ch];
    for (int c = 0; c < NCH; c++) begin
      sel = wr_en && (int'(wr_ch) == c);
      set = 0;
      m_tick[c] = 0;
      if (sel && wr_sel == 2'd1) begin
        m_en[c]  = wr_data[0];
        m_per[c] = wr_data[1];
        m_ien[c] = wr_data[2];
        if (wr_data[0]) m_count[c] = m_reload[c];
      end else if (m_en[c] && strobe) begin
        if (m_count[c] == 0) begin
          m_tick[c] = 1;
          set = 1;
          if (m_per[c]) m_count[c] = m_reload[c];
          else m_en[c] = 0;
        end else begin
          m_count[c] = m_count[c] - 1;
        end
      end
      if (sel && wr_sel == 2'd0) m_reload[c] = int'(wr_data);
      m_pend[c] = set | (m_pend[c] & !irq_ack[c]);
    end
    if (wr_en && wr_sel == 2'd2 && int'(wr_ch) < NCH) begin
      m_presc = int'(wr_data) % (1 << PW);
      m_pc = 0;
    end else if (strobe) begin
      m_pc = 0;
    end else if (ena) begin
      m_pc = m_pc + 1;
    end
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] et;
    logic [NCH-1:0] ep;
    logic           ei;
    ei = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      et[c] = m_tick[c];
      ep[c] = m_pend[c];
      ei    = ei | (m_pend[c] & m_ien[c]);
    end
    chk("tick", {29'd0, tick}, {29'd0, et});
    chk("irq_pend", {29'd0, irq_pend}, {29'd0, ep});
    chk("irq", {31'd0, irq}, {31'd0, ei});
`ifdef PIT_READBACK_EN
    chk("rd_count", {16'd0, rd_count}, m_rd);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic wr(input int sel, input int ch, input int data);
    wr_en = 1'b1; wr_sel = sel[1:0]; wr_ch = ch[1:0]; wr_data = data[CW-1:0];
    cycle();
    wr_en = 1'b0;
  endtask

  initial begin
    int first;
    int second;
    int nt;
    int nt1;
    rst_n = 1'b0; ena = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_sel = '0;
    wr_data = '0; irq_ack = '0; rd_ch = '0;
    model_reset();
    #1;
    chk("reset_tick", {29'd0, tick}, 0);
    chk("reset_pend", {29'd0, irq_pend}, 0);
    chk("reset_irq", {31'd0, irq}, 0);
`ifdef PIT_READBACK_EN
    chk("reset_rd", {16'd0, rd_count}, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Periodic R=3, P=0: ticks 4 cycles after enable, every 4 cycles.
    ena = 1'b1;
    wr(0, 0, 3);
    wr(1, 0, 3'b011);
    first = -1; nt = 0;
    for (int k = 1; k <= 13; k++) begin
      cycle();
      if (tick[0] === 1'b1) begin
        nt++;
        if (first < 0) first = k;
      end
    end
    chk("p1_first_tick", first, 4);
    chk("p1_tick_count", nt, 3);
    chk("p1_pend", {31'd0, irq_pend[0]}, 1);
    chk("p1_irq_masked", {31'd0, irq}, 0);
    wr(1, 0, 3'b111);
    chk("p1_irq_unmasked", {31'd0, irq}, 1);
    irq_ack = 3'b001;
    cycle();
    irq_ack = '0;
    chk("p1_ack_clear", {31'd0, irq_pend[0]}, 0);
    chk("p1_irq_after_ack", {31'd0, irq}, 0);
    wr(1, 0, 0);

    // One-shot R=1, P=2 on channel 1: one tick after 6 cycles, then silence.
    ena = 1'b0;
    wr(2, 0, 2);
    wr(0, 1, 1);
    wr(1, 1, 3'b001);
    ena = 1'b1;
    first = -1; nt = 0;
    for (int k = 1; k <= 56; k++) begin
      cycle();
      if (tick[1] === 1'b1) begin
        nt++;
        if (first < 0) first = k;
      end
    end
    chk("os_first_tick", first, 6);
    chk("os_tick_count", nt, 1);
    chk("os_pend", {31'd0, irq_pend[1]}, 1);
    wr(1, 3, 3'b011);                       // no channel 3: ignored
    wr(2, 3, 7);                            // ignored as well
    repeat (8) cycle();

    // Two channels, R=2 and R=4, P=0; ack coinciding with expiry loses.
    ena = 1'b0;
    wr(2, 0, 0);
    wr(0, 0, 2);
    wr(0, 1, 4);
    wr(1, 0, 3'b011);
    wr(1, 1, 3'b011);
    irq_ack = '1;
    cycle();
    irq_ack = '0;
    ena = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      irq_ack[0] = (k == 4 || k == 6 || k == 7);
      cycle();
      irq_ack = '0;
      chk("two_tick0", {31'd0, tick[0]}, (k % 3 == 0) ? 1 : 0);
      chk("two_tick1", {31'd0, tick[1]}, (k % 5 == 0) ? 1 : 0);
      if (k == 4) chk("two_ack_clears", {31'd0, irq_pend[0]}, 0);
      if (k == 6) chk("two_set_wins", {31'd0, irq_pend[0]}, 1);
      if (k == 7) chk("two_late_ack", {31'd0, irq_pend[0]}, 0);
    end
    wr(1, 0, 0);
    wr(1, 1, 0);

    // R=9, P=1 with a 7-cycle ena gap and a mid-period reload write of 5.
    ena = 1'b0;
    wr(2, 0, 1);
    wr(0, 0, 9);
    wr(1, 0, 3'b011);
    first = -1; second = -1;
    for (int k = 1; k <= 41; k++) begin
      ena = !(k >= 6 && k <= 12);
      if (k == 14) begin
        wr_en = 1'b1; wr_sel = 2'd0; wr_ch = 2'd0; wr_data = 16'd5;
      end
      cycle();
      wr_en = 1'b0;
      if (tick[0] === 1'b1) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    ena = 1'b1;
    chk("gap_first_tick", first, 27);
    chk("gap_second_tick", second, 39);

    // Asynchronous reset while running.
    irq_ack = '0;
    @(posedge clk);
    model_step();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_tick", {29'd0, tick}, 0);
    chk("async_rst_pend", {29'd0, irq_pend}, 0);
    chk("async_rst_irq", {31'd0, irq}, 0);
`ifdef PIT_READBACK_EN
    chk("async_rst_rd", {16'd0, rd_count}, 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    nt1 = 0;
    for (int k = 1; k <= 25; k++) begin
      cycle();
      if (tick !== '0) nt1++;
    end
    chk("post_rst_no_tick", nt1, 0);

`ifdef PIT_READBACK_EN
    // Readback follows the counter one cycle behind.
    ena = 1'b0;
    wr(0, 0, 10);
    rd_ch = 2'd0;
    wr(1, 0, 3'b011);
    ena = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      chk("rb_track", {16'd0, rd_count}, 11 - k);
    end
    rd_ch = 2'd3;
    cycle();
    chk("rb_out_of_range", {16'd0, rd_count}, 0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      ena     = ($urandom % 8) != 0;
      wr_en   = ($urandom % 4) == 0;
      wr_sel  = 2'($urandom % 4);
      wr_ch   = 2'($urandom % 4);
      case (wr_sel)
        2'd0:    wr_data = 16'($urandom % 6);
        2'd1:    wr_data = 16'($urandom % 8);
        2'd2:    wr_data = 16'($urandom % 3);
        default: wr_data = 16'($urandom);
      endcase
      irq_ack = (($urandom % 6) == 0) ? 3'($urandom) : 3'd0;
      rd_ch   = 2'($urandom % 4);
      cycle();
    end
    wr_en = 1'b0;
    irq_ack = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pit_multi.md
# pit_multi

Parametrised multi-channel programmable interval timer, the successor to the single-channel minipit. NUM_CH independent down-counters share one programmable prescaler. Each channel runs one-shot or periodic, emits a one-cycle tick on expiry and latches a maskable interrupt-pending bit. It sits behind the tile's register-write path, and its ticks and IRQ drive uo_out.

## Interface
- NUM_CH, default 2: number of timer channels (1..8)
- CNT_W, default 16: counter, reload and write-data width (≥ PRESC_W, ≥ 3)
- PRESC_W, default 8: prescaler width
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  count enable; low freezes the prescaler and all counters, while writes are still accepted
- wr_en  in  1  register write strobe
- wr_ch  in  $clog2(NUM_CH) (min 1)  target channel
- wr_sel  in  2  0 = reload, 1 = control, 2 = prescaler (global), 3 = ignored
- wr_data  in  CNT_W  write data; control uses bits [2:0] = {irq_en, periodic, en}; prescaler uses [PRESC_W-1:0]
- irq_ack  in  NUM_CH  per-channel pending clear
- tick  out  NUM_CH  one-cycle expiry pulse per channel, registered
- irq_pend  out  NUM_CH  pending bits, registered
- irq  out  1  OR of (irq_pend & irq_en)
- rd_ch  in  $clog2(NUM_CH)  readback select (PIT_READBACK_EN only)
- rd_count  out  CNT_W  readback of the selected channel's counter (PIT_READBACK_EN only)

## Operation
- Reset values: all reload, count, control, prescaler and prescaler-counter registers are 0; tick = 0, irq_pend = 0, irq = 0, rd_count = 0.
- Prescaler: pc counts 0..presc. strobe = ena & (pc == presc); on strobe pc goes to 0, otherwise it increments while ena is high. P = 0 gives a strobe every ena cycle.
- Per-channel state: IDLE (en = 0) or RUN (en = 1).
  - Writing control with en = 1 loads count ← reload and enters RUN. This applies even when already running, which restarts the channel.
  - Writing control with en = 0 enters IDLE; count holds.
- RUN on strobe:
  - count ≠ 0: count ← count − 1.
  - count = 0: the channel expires. tick = 1 for one cycle and irq_pend is set. Periodic: count ← reload. One-shot: en ← 0, count stays 0.
- Period = (R+1)·(P+1) ena-cycles.
- Writing reload while running changes only the next reload; the current count is untouched.
- Writing the prescaler sets presc and forces pc ← 0, which restarts the strobe phase.
- A write to a channel ≥ NUM_CH, or with wr_sel = 3, is ignored.
- Interrupts:
  - irq_pend[i] is set on expiry regardless of irq_en; only irq is masked by irq_en.
  - irq_ack[i] clears irq_pend[i].
  - A set and an ack in the same cycle: set wins.
- Arithmetic is unsigned with no wrap below 0. The zero test precedes the decrement.

## Timing
- All writes take effect at the edge where wr_en is sampled high; the new values are visible the next cycle.
- A control write and a strobe on the same edge: the write wins and no decrement or expiry occurs on that edge for that channel.
- A prescaler write and a strobe on the same edge: pc ← 0, and the channels still act on that strobe.
- tick and the irq_pend set are registered on the expiring strobe edge, so they are visible the cycle after the strobe cycle.
- irq is combinational from registered state: it follows irq_pend with no extra latency.
- ena deasserted mid-count: no strobe is generated and state holds exactly. Reasserting resumes from the same pc and count values.
- rst_n asserted mid-operation clears everything asynchronously. The first strobe after release is at pc = presc = 0, i.e. the first ena cycle.

## Configuration
- PIT_READBACK_EN defined:
  - rd_ch and rd_count ports exist.
  - rd_count ← count[rd_ch] every cycle (1-cycle latency).
  - rd_ch ≥ NUM_CH returns 0.
- PIT_READBACK_EN undefined: the ports are absent and no readback logic is built. Timer behaviour is identical in both builds.

## Test plan
- Periodic, P = 0, R = 3, ena = 1, enable at edge t0 → tick high in cycles t4+1, t8+1, t12+1 (period 4); irq_pend[0] = 1 after the first expiry; irq = 1 only with irq_en = 1.
- One-shot, P = 2, R = 1 → single tick after 6 cycles, en cleared, no further ticks for 50 cycles, count = 0.
- Two channels: ch0 periodic R = 2, ch1 periodic R = 4, P = 0 → ticks every 3 and every 5 cycles; irq_ack[0] pulsed on the cycle of ch0's next expiry leaves irq_pend[0] = 1 (set wins); an ack in a later cycle clears it.
- ena toggled low for 7 cycles mid-count (R = 9, P = 1) → the expiry is delayed by exactly 7 cycles; a reload write of 5 during the run leaves the current period at 20 and makes the next period 12.
- rst_n pulsed low asynchronously while running → all outputs are 0 immediately, and no tick follows until re-enabled.
- PIT_READBACK_EN: with R = 10, P = 0, rd_ch = 0 → rd_count tracks 10, 9, 8… one cycle behind count; rd_ch = NUM_CH reads 0.
